// File: rtl/dm_arb_pkg.sv
// =============================================================================
// dm_arb_pkg: shared types and constants for the data-memory port arbiter.
// Revision: 1.0
// =============================================================================
`default_nettype none

package dm_arb_pkg;

  localparam int DEF_AW    = 6;
  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 64;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dm_port_arbiter_rr_arb2.sv
// =============================================================================
// rr_arb2: two-way round-robin arbiter; the last-grant flop favours master 0 first.
// Revision: 1.0
// =============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Index of the master accepted most recently.
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = r_last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)      r_last <= 1'b1;
    else if (accept) r_last <= gnt[1];
  end

endmodule

`default_nettype wire

// File: rtl/dm_port_arbiter.sv
// =============================================================================
// dm_port_arbiter: shares the data memory port between two masters and runs a fill sweep.
// Revision: 1.0
// =============================================================================
`default_nettype none

module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [1:0]    m0_mode,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [1:0]    m1_mode,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] dm_rA,
  output logic [DW-1:0] dm_D,
  output logic          dm_WE,
  output logic [1:0]    dm_mode,
  input  logic [DW-1:0] dm_A_out
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_fill_val;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic          r_fill_done;

  logic [1:0]    w_gnt;
  logic          w_arb_en;
  logic          w_acc0;
  logic          w_acc1;
  logic          w_fill_go;
  logic          w_fill_last;

  // A fill request in IDLE wins over both masters in the same cycle.
  assign w_fill_go   = (r_state == IDLE) && fill_start;
  assign w_arb_en    = (r_state == IDLE) && !fill_start;
  assign w_acc0      = m0_req && w_gnt[0];
  assign w_acc1      = m1_req && w_gnt[1];
  assign w_fill_last = (r_cnt == LAST_ADDR);

  rr_arb2 u_arb (
    .clk    (clk),
    .clr_n  (clr_n),
    .req    ({m1_req, m0_req}),
    .en     (w_arb_en),
    .accept (w_acc0 || w_acc1),
    .gnt    (w_gnt)
  );

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign fill_busy = (r_state == FILL);
  assign fill_done = r_fill_done;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Idle memory bus carries master 0's fields with the write enable low.
  always_comb begin
    w_state_nxt = r_state;
    dm_rA       = m0_addr;
    dm_D        = m0_wdata;
    dm_mode     = m0_mode;
    dm_WE       = 1'b0;
    case (r_state)
      IDLE: begin
        if (fill_start) begin
          w_state_nxt = FILL;
        end else if (w_acc1) begin
          dm_rA   = m1_addr;
          dm_D    = m1_wdata;
          dm_mode = m1_mode;
          dm_WE   = m1_we;
        end else if (w_acc0) begin
          dm_WE   = m0_we;
        end
      end
      FILL: begin
        dm_rA   = r_cnt;
        dm_D    = r_fill_val;
        dm_mode = MODE_WORD;
        dm_WE   = 1'b1;
        if (w_fill_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt       <= '0;
      r_fill_val  <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= (r_state == FILL) && w_fill_last;
      r_rvalid0   <= w_acc0;
      r_rvalid1   <= w_acc1;
      if (w_fill_go) begin
        r_cnt      <= '0;
        r_fill_val <= fill_value;
      end else if (r_state == FILL) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Read-before-write: the pre-write word is captured on the accept edge.
      if (w_acc0) r_rdata0 <= dm_A_out;
      if (w_acc1) r_rdata1 <= dm_A_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
// =============================================================================
// tb_dm_port_arbiter: self-checking bench with a behavioural memory and reference model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_dm_port_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk   = 1'b0;
  logic          clr_n = 1'b1;
  logic          m0_req, m0_we, m1_req, m1_we, fill_start;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [1:0]    m0_mode, m1_mode;
  logic [DW-1:0] m0_wdata, m1_wdata, fill_value;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, fill_busy, fill_done, dm_WE;
  logic [DW-1:0] m0_rdata, m1_rdata, dm_D, dm_A_out;
  logic [AW-1:0] dm_rA;
  logic [1:0]    dm_mode;

  int errors = 0;
  int checks = 0;
  int ref_last;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] mem [DEPTH];

  dm_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_mode(m0_mode), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_mode(m1_mode), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .dm_rA(dm_rA), .dm_D(dm_D), .dm_WE(dm_WE), .dm_mode(dm_mode), .dm_A_out(dm_A_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [1:0] md);
    case (md)
      2'b01:   return {old[31:16], d[15:0]};
      2'b10:   return {old[31:8], d[7:0]};
      default: return d;
    endcase
  endfunction

  // Memory model: combinational read, partial writes by mode.
  assign dm_A_out = mem[dm_rA];
  always @(posedge clk) if (dm_WE) mem[dm_rA] <= merge(mem[dm_rA], dm_D, dm_mode);

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    m1_req = 1'b1; m1_addr = a[AW-1:0]; m1_we = 1'b1; m1_mode = 2'b00; m1_wdata = d;
    step;
    m1_req = 1'b0; m1_we = 1'b0;
    ref_mem[a] = d;
    ref_last = 1;
  endtask

  task automatic read_word(input int a, output logic [31:0] d);
    m0_req = 1'b1; m0_addr = a[AW-1:0]; m0_we = 1'b0;
    step;
    d = m0_rdata;
    m0_req = 1'b0;
    ref_last = 0;
  endtask

  task automatic test_reset;
    #1 clr_n = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, fill_busy, fill_done, dm_WE} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, fill_busy, fill_done, dm_WE});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    step; step;
    clr_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) write_word(a, $urandom | 32'h1);
    // Reset right after an accept must drop the pending read.
    m0_req = 1'b1; m0_addr = 6'd7; m0_we = 1'b0;
    step;
    m0_req = 1'b0;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== ref_mem[7]) begin
      errors++;
      $display("FAIL pre_reset_read: got v=%b d=%h want v=1 d=%h", m0_rvalid, m0_rdata, ref_mem[7]);
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_txn: got v=%b d=%h want v=0 d=0", m0_rvalid, m0_rdata);
    end
    step;
    clr_n = 1'b1;
    ref_last = 1;
  endtask

  task automatic test_contention;
    logic [1:0] exp;
    m0_req = 1'b1; m0_addr = 6'd11; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 6'd12; m1_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if ({m1_gnt, m0_gnt} !== exp) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: got %b want %b", i, {m1_gnt, m0_gnt}, exp);
      end
      step;
      checks++;
      if ({m1_rvalid, m0_rvalid} !== exp ||
          (exp[0] && m0_rdata !== ref_mem[11]) || (exp[1] && m1_rdata !== ref_mem[12])) begin
        errors++;
        $display("FAIL contention_rd[%0d]: got v=%b d0=%h d1=%h want v=%b d0=%h d1=%h", i,
                 {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, exp, ref_mem[11], ref_mem[12]);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    ref_last = 1;
    step;
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL contention_idle: got %b want 00", {m1_rvalid, m0_rvalid});
    end
  endtask

  task automatic test_single_read;
    write_word(5, 32'hDEADBEEF);
    m0_req = 1'b1; m0_addr = 6'd5; m0_we = 1'b0;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt: got %b%b want 01", m1_gnt, m0_gnt);
    end
    step;
    m0_req = 1'b0;
    ref_last = 0;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_rd: got v0=%b d=%h v1=%b want v0=1 d=deadbeef v1=0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    step;
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: got rvalid=%b want 0", m0_rvalid);
    end
  endtask

  task automatic test_partial_write;
    logic [31:0] d;
    write_word(9, 32'h11223344);
    m1_req = 1'b1; m1_addr = 6'd9; m1_we = 1'b1; m1_mode = 2'b10; m1_wdata = 32'hAABBCCDD;
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || dm_WE !== 1'b1 || dm_mode !== 2'b10 || dm_rA !== 6'd9 || dm_D !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL partial_bus: got g=%b we=%b m=%b a=%0d d=%h want 1 1 10 9 aabbccdd",
               m1_gnt, dm_WE, dm_mode, dm_rA, dm_D);
    end
    step;
    m1_req = 1'b0; m1_we = 1'b0; m1_mode = 2'b00;
    ref_last = 1;
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL partial_rbw: got v=%b d=%h want v=1 d=11223344", m1_rvalid, m1_rdata);
    end
    ref_mem[9] = 32'h112233DD;
    read_word(9, d);
    checks++;
    if (d !== 32'h112233DD) begin
      errors++;
      $display("FAIL partial_readback: got %h want 112233dd", d);
    end
  endtask

  task automatic test_random;
    logic        p [2];
    logic [5:0]  ad [2];
    logic        we [2];
    logic [1:0]  md [2];
    logic [31:0] wd [2];
    logic        g0, g1;
    int          w;
    logic [31:0] exp_rd;
    p[0] = 1'b0; p[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!p[m] && $urandom_range(0, 3) != 0) begin
          p[m] = 1'b1; ad[m] = 6'($urandom); we[m] = 1'($urandom);
          md[m] = 2'($urandom); wd[m] = $urandom;
        end
      end
      m0_req = p[0]; m0_addr = ad[0]; m0_we = we[0]; m0_mode = md[0]; m0_wdata = wd[0];
      m1_req = p[1]; m1_addr = ad[1]; m1_we = we[1]; m1_mode = md[1]; m1_wdata = wd[1];
      #1;
      g0 = p[0] && (!p[1] || ref_last == 1);
      g1 = p[1] && (!p[0] || ref_last == 0);
      w  = g1 ? 1 : 0;
      checks++;
      if ({m1_gnt, m0_gnt} !== {g1, g0}) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", c, {m1_gnt, m0_gnt}, {g1, g0});
      end
      checks++;
      if (g0 || g1) begin
        if (dm_WE !== we[w] || dm_rA !== ad[w] || dm_D !== wd[w] || dm_mode !== md[w]) begin
          errors++;
          $display("FAIL rand_bus[%0d]: got we=%b a=%0d d=%h m=%b want %b %0d %h %b", c,
                   dm_WE, dm_rA, dm_D, dm_mode, we[w], ad[w], wd[w], md[w]);
        end
      end else if (dm_WE !== 1'b0 || dm_rA !== ad[0] || dm_D !== wd[0] || dm_mode !== md[0]) begin
        errors++;
        $display("FAIL rand_idle_bus[%0d]: got we=%b a=%0d d=%h m=%b want 0 %0d %h %b", c,
                 dm_WE, dm_rA, dm_D, dm_mode, ad[0], wd[0], md[0]);
      end
      exp_rd = ref_mem[ad[w]];
      if (g0 || g1) begin
        if (we[w]) ref_mem[ad[w]] = merge(ref_mem[ad[w]], wd[w], md[w]);
        ref_last = w;
      end
      step;
      checks++;
      if ({m1_rvalid, m0_rvalid} !== {g1, g0} ||
          (g0 && m0_rdata !== exp_rd) || (g1 && m1_rdata !== exp_rd)) begin
        errors++;
        $display("FAIL rand_rd[%0d]: got v=%b d0=%h d1=%h want v=%b d=%h", c,
                 {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata, {g1, g0}, exp_rd);
      end
      if (g0 || g1) p[w] = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    step;
  endtask

  task automatic test_fill;
    logic [31:0] d;
    m0_req = 1'b1; m0_addr = 6'd3; m0_we = 1'b0;
    fill_value = 32'h0000CAFE; fill_start = 1'b1;
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fill_start_gnt: got %b%b want 00", m1_gnt, m0_gnt);
    end
    step;
    fill_start = 1'b0; fill_value = $urandom;
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      checks++;
      if ({m1_gnt, m0_gnt, fill_busy, dm_WE, dm_mode, fill_done} !== 7'b0011000 ||
          dm_rA !== AW'(k - 1) || dm_D !== 32'h0000CAFE) begin
        errors++;
        $display("FAIL fill_cycle[%0d]: got g=%b%b busy=%b we=%b m=%b done=%b a=%0d d=%h want 00 1 1 00 0 %0d 0000cafe",
                 k, m1_gnt, m0_gnt, fill_busy, dm_WE, dm_mode, fill_done, dm_rA, dm_D, k - 1);
      end
      step;
    end
    #1;
    checks++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0 || m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL fill_done: got done=%b busy=%b gnt0=%b want 1 0 1", fill_done, fill_busy, m0_gnt);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 32'h0000CAFE;
    step;
    m0_req = 1'b0;
    ref_last = 0;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000CAFE || fill_done !== 1'b0) begin
      errors++;
      $display("FAIL fill_held_read: got v=%b d=%h done=%b want 1 0000cafe 0", m0_rvalid, m0_rdata, fill_done);
    end
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, d);
      checks++;
      if (d !== 32'h0000CAFE) begin
        errors++;
        $display("FAIL fill_word[%0d]: got %h want 0000cafe", a, d);
      end
    end
  endtask

  task automatic test_fill_restart;
    logic [31:0] v;
    v = $urandom;
    fill_value = v; fill_start = 1'b1;
    step;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 30) begin fill_start = 1'b1; fill_value = ~v; end
      else fill_start = 1'b0;
      #1;
      checks++;
      if (fill_busy !== 1'b1 || dm_WE !== 1'b1 || fill_done !== 1'b0 ||
          dm_rA !== AW'(k - 1) || dm_D !== v) begin
        errors++;
        $display("FAIL restart_cycle[%0d]: got busy=%b we=%b done=%b a=%0d d=%h want 1 1 0 %0d %h",
                 k, fill_busy, dm_WE, fill_done, dm_rA, dm_D, k - 1, v);
      end
      step;
    end
    fill_start = 1'b0;
    #1;
    checks++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got done=%b busy=%b want 1 0", fill_done, fill_busy);
    end
    step;
    checks++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_after: got done=%b busy=%b want 0 0", fill_done, fill_busy);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = v;
  endtask

  task automatic test_reset_abort;
    logic [31:0] v, d, exp;
    logic        seen;
    v = ~ref_mem[0];
    fill_value = v; fill_start = 1'b1;
    step;
    fill_start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      #1;
      checks++;
      if (fill_busy !== 1'b1 || dm_WE !== 1'b1 || dm_rA !== AW'(k - 1)) begin
        errors++;
        $display("FAIL abort_cycle[%0d]: got busy=%b we=%b a=%0d want 1 1 %0d", k, fill_busy, dm_WE, dm_rA, k - 1);
      end
      if (k < 21) step;
    end
    clr_n = 1'b0;
    #1;
    checks++;
    if ({fill_busy, fill_done, dm_WE, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 7'b0) begin
      errors++;
      $display("FAIL abort_reset_vals: got %b want 0000000",
               {fill_busy, fill_done, dm_WE, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt});
    end
    step; step;
    clr_n = 1'b1;
    ref_last = 1;
    seen = 1'b0;
    for (int j = 0; j < 70; j++) begin
      #1;
      if (fill_done || fill_busy) seen = 1'b1;
      step;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done/busy seen=%b want 0", seen);
    end
    for (int a = 0; a < 20; a++) ref_mem[a] = v;
    for (int a = 0; a < DEPTH; a++) begin
      exp = ref_mem[a];
      read_word(a, d);
      checks++;
      if (d !== exp) begin
        errors++;
        $display("FAIL abort_word[%0d]: got %h want %h", a, d, exp);
      end
    end
  endtask

  initial begin
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_mode = 2'b00; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_mode = 2'b00; m1_wdata = '0;
    fill_start = 1'b0; fill_value = '0;
    ref_last = 1;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    test_reset;
    test_contention;
    test_single_read;
    test_partial_write;
    test_random;
    test_fill;
    test_fill_restart;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the data memory's single read-write port between two requesters: master 0, the pipeline MEM stage, and master 1, the debug/loader port. Arbitrates one transaction per cycle with round-robin fairness and returns registered read data. Also contains a fill sequencer that writes a programmable value to every word, because the memory's own clear can only load zero. Sits directly in front of the 64x32 data memory and drives its rA/D/WE/mode inputs.

## Interface
- AW, 6: address width
- DW, 32: data width
- DEPTH, 64: words swept by a fill; must equal 2**AW
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request; held until granted
- m0_addr / m1_addr  in  AW  word address
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_mode / m1_mode  in  2  00 word, 01 low half, 10 low byte, 11 treated as word
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  combinational grant; the transaction is accepted when req && gnt
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse, the cycle after accept
- m0_rdata / m1_rdata  out  DW  registered word at addr, valid while rvalid
- fill_start  in  1  starts a fill sweep (level, sampled in IDLE)
- fill_value  in  DW  fill data, captured at start
- fill_busy  out  1  high while the FILL state is active
- fill_done  out  1  one-cycle pulse after the last fill write
- dm_rA  out  AW  memory address
- dm_D  out  DW  memory write data
- dm_WE  out  1  memory write enable
- dm_mode  out  2  memory write mode
- dm_A_out  in  DW  memory combinational read data at dm_rA

## Operation
- States: IDLE, FILL.
- IDLE with fill_start=1:
  - no grant in that cycle
  - capture fill_value
  - clear the address counter
  - go to FILL; fill_start takes priority over requests
- IDLE with fill_start=0:
  - one requester: grant it
  - both requesting: grant the master not granted most recently
  - last-grant pointer updates only on accept
- Accept cycle:
  - dm_rA = addr, dm_D = wdata, dm_mode = mode, dm_WE = we
  - rdata register loads dm_A_out. Writes therefore return the pre-write value (read-before-write).
  - rvalid goes high for the accepted master next cycle
- No accept: dm_WE = 0. dm_rA, dm_D and dm_mode hold master 0's inputs.
- FILL:
  - both gnt = 0
  - dm_WE = 1, dm_mode = 00, dm_D = captured value, dm_rA = counter
  - the counter increments each cycle
  - after the write at address DEPTH-1: go to IDLE and pulse fill_done on the next cycle
  - fill_start during FILL is ignored; the sweep is not restarted
- Requests held during FILL are granted normally after return to IDLE.
- Mode 11 is passed to the memory unchanged; the memory treats it as a word write.

## Timing
- Grant: combinational, 0 cycles from req in IDLE. Back-to-back accepts on consecutive cycles are allowed for the same or alternating masters.
- Read latency: 1 cycle (accept edge → rvalid/rdata).
- Fill: DEPTH write cycles plus one IDLE cycle. fill_done rises DEPTH+1 cycles after the fill_start cycle, coincident with the first cycle back in IDLE.
- Reset values:
  - state IDLE
  - last-grant pointer = 1, so master 0 wins the first contention
  - counter 0, captured fill value 0
  - all rvalid 0, rdata 0
  - fill_busy 0, fill_done 0
- Reset mid-fill: the sweep is abandoned and memory is left partially filled. No fill_done.
- Reset mid-transaction: a pending rvalid is dropped.
- Counter wraps naturally at 2**AW. The FILL exit is decided by count == DEPTH-1, not by the wrap.

## Structure
- Package dm_arb_pkg:
  - state enum {IDLE, FILL}
  - mode constants MODE_WORD=2'b00, MODE_HALF=2'b01, MODE_BYTE=2'b10
  - default AW/DW/DEPTH localparams
- Sub-module rr_arb2: two-way round-robin.
  - inputs req[1:0], en, accept
  - output gnt[1:0]
  - owns the last-grant flop
  - top instantiates it once and forces en=0 in FILL or when fill_start is seen in IDLE.

## Test plan
- Single read: preload word 5 = 0xDEADBEEF; m0 reads addr 5 → m0_gnt=1 same cycle, m0_rvalid next cycle with 0xDEADBEEF; m1_rvalid stays 0.
- Contention: m0 and m1 both request for 4 cycles → grants alternate m0, m1, m0, m1 (m0 first after reset); each rvalid pulses once, one cycle after its grant.
- Partial write: word 9 = 0x11223344; m1 writes 0xAABBCCDD to addr 9 with mode 10 → its rdata returns 0x11223344, a later read returns 0x112233DD.
- Fill: fill_start with fill_value=0x0000CAFE, m0_req held high → no grants for 64 cycles; fill_busy high; fill_done pulses 65 cycles after start, and m0 is granted in that same cycle; every word reads 0x0000CAFE.
- Fill_start during FILL at cycle 30 → ignored; fill_done still pulses 65 cycles after the original start.
- Reset abort: assert clr_n low at fill address 20 → outputs return to reset values immediately; words 0–19 hold the fill value, word 20 onward unchanged; no fill_done.
